// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard: per-register in-flight producer scoreboard that captures
// broadcast results and forwards them to decode, with zero-latency bypass.
module bypass_scoreboard #(
  parameter  int XLEN  = 64,
  parameter  int NREG  = 32,
  parameter  int NRD   = 2,
  parameter  int NRES  = 3,
  parameter  int TAG_W = 4,
  localparam int LW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic                 issue_rd_wen,
  input  logic [LW-1:0]        issue_rd,
  input  logic [TAG_W-1:0]     issue_tag,
  input  logic [NRES-1:0]      res_valid,
  input  logic [NRES*LW-1:0]   res_rd,
  input  logic [NRES*TAG_W-1:0] res_tag,
  input  logic [NRES*XLEN-1:0] res_data,
  input  logic                 cmt_valid,
  input  logic [LW-1:0]        cmt_rd,
  input  logic [TAG_W-1:0]     cmt_tag,
  input  logic                 flush,
  input  logic [NRD*LW-1:0]    rs_addr,
  output logic [NRD-1:0]       fwd_sel,
  output logic [NRD*XLEN-1:0]  fwd_data,
  output logic                 stall,
  output logic [31:0]          stall_cycles
);

  logic [NREG-1:0]            pend_q, pend_d;
  logic [NREG-1:0]            rdy_q, rdy_d;
  logic [NREG-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [NREG-1:0][XLEN-1:0]  val_q, val_d;
  logic [31:0]                scnt_q, scnt_d;

  logic [NREG-1:0]            hit;
  logic [NREG-1:0][XLEN-1:0]  hit_data;
  logic [NRD-1:0]             stall_req;
  logic                       issue_en;

  assign issue_en = issue_valid & issue_rd_wen & (issue_rd != '0);

  // Per-register result match; scanning downward lets the lowest port win.
  always_comb begin
    hit      = '0;
    hit_data = '0;
    for (int r = 0; r < NREG; r++) begin
      for (int i = NRES - 1; i >= 0; i--) begin
        if (res_valid[i] && pend_q[r] &&
            res_rd[i*LW +: LW] == LW'(r) &&
            res_tag[i*TAG_W +: TAG_W] == tag_q[r]) begin
          hit[r]      = 1'b1;
          hit_data[r] = res_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    rdy_d  = rdy_q;
    tag_d  = tag_q;
    val_d  = val_q;
    for (int r = 0; r < NREG; r++) begin
      if (flush) begin
        pend_d[r] = 1'b0;
        rdy_d[r]  = 1'b0;
      end else if (issue_en && issue_rd == LW'(r)) begin
        pend_d[r] = 1'b1;
        rdy_d[r]  = 1'b0;
        tag_d[r]  = issue_tag;
      end else if (cmt_valid && pend_q[r] &&
                   cmt_rd == LW'(r) &&
                   cmt_tag == tag_q[r]) begin
        pend_d[r] = 1'b0;
        rdy_d[r]  = 1'b0;
      end else if (hit[r]) begin
        rdy_d[r]  = 1'b1;
        val_d[r]  = hit_data[r];
      end
    end
  end

  always_comb begin
    logic [LW-1:0] rs;
    rs        = '0;
    fwd_sel   = '0;
    fwd_data  = '0;
    stall_req = '0;
    for (int j = 0; j < NRD; j++) begin
      rs = rs_addr[j*LW +: LW];
      if (rs != '0 && pend_q[rs]) begin
        fwd_sel[j] = 1'b1;
        if (rdy_q[rs]) begin
          fwd_data[j*XLEN +: XLEN] = val_q[rs];
        end else if (hit[rs]) begin
          fwd_data[j*XLEN +: XLEN] = hit_data[rs];
        end else begin
          stall_req[j] = 1'b1;
        end
      end
    end
  end

  assign stall = (|stall_req) & ~flush;

  always_comb begin
    scnt_d = scnt_q;
    if (stall && scnt_q != '1) begin
      scnt_d = scnt_q + 32'd1;
    end
  end

  assign stall_cycles = scnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      rdy_q  <= '0;
      tag_q  <= '0;
      val_q  <= '0;
      scnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      rdy_q  <= rdy_d;
      tag_q  <= tag_d;
      val_q  <= val_d;
      scnt_q <= scnt_d;
    end
  end

endmodule

// File: tb/tb_bypass_scoreboard.sv
// tb_bypass_scoreboard: directed scenarios plus a randomized run checked
// against an event-ordered scoreboard model.
module tb_bypass_scoreboard;

  localparam int XLEN  = 64;
  localparam int NREG  = 32;
  localparam int NRD   = 2;
  localparam int NRES  = 3;
  localparam int TAG_W = 4;
  localparam int LW    = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic issue_valid, issue_rd_wen;
  logic [LW-1:0] issue_rd;
  logic [TAG_W-1:0] issue_tag;
  logic [NRES-1:0] res_valid;
  logic [NRES*LW-1:0] res_rd;
  logic [NRES*TAG_W-1:0] res_tag;
  logic [NRES*XLEN-1:0] res_data;
  logic cmt_valid;
  logic [LW-1:0] cmt_rd;
  logic [TAG_W-1:0] cmt_tag;
  logic flush;
  logic [NRD*LW-1:0] rs_addr;
  logic [NRD-1:0] fwd_sel;
  logic [NRD*XLEN-1:0] fwd_data;
  logic stall;
  logic [31:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  bit mp[NREG];
  bit mr[NREG];
  int mt[NREG];
  logic [XLEN-1:0] mv[NREG];
  int mcnt;

  bypass_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NRES(NRES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd_wen(issue_rd_wen),
    .issue_rd(issue_rd), .issue_tag(issue_tag),
    .res_valid(res_valid), .res_rd(res_rd),
    .res_tag(res_tag), .res_data(res_data),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag),
    .flush(flush), .rs_addr(rs_addr),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .stall(stall), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd_wen = 0; issue_rd = '0; issue_tag = '0;
    res_valid = '0; res_rd = '0; res_tag = '0; res_data = '0;
    cmt_valid = 0; cmt_rd = '0; cmt_tag = '0;
    flush = 0; rs_addr = '0;
  endtask

  task automatic rst_pulse();
    idle();
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  task automatic set_issue(input logic [LW-1:0] rd, input logic [TAG_W-1:0] t);
    issue_valid = 1; issue_rd_wen = 1; issue_rd = rd; issue_tag = t;
  endtask

  task automatic set_cmt(input logic [LW-1:0] rd, input logic [TAG_W-1:0] t);
    cmt_valid = 1; cmt_rd = rd; cmt_tag = t;
  endtask

  task automatic set_res(input int i, input logic [LW-1:0] rd,
                         input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    res_valid[i] = 1'b1;
    res_rd[i*LW +: LW] = rd;
    res_tag[i*TAG_W +: TAG_W] = t;
    res_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic set_rs(input logic [LW-1:0] a0, input logic [LW-1:0] a1);
    rs_addr = {a1, a0};
  endtask

  task automatic test_reset();
    idle(); rst_n = 0;
    tick(); rst_n = 1;
    set_rs(5'd5, 5'd0);
    @(negedge clk);
    vectors++; if (fwd_sel !== 2'b00) begin miscompares++; $display("FAIL reset_sel: got %b want 00", fwd_sel); end
    vectors++; if (fwd_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", fwd_data); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
    vectors++; if (stall_cycles !== 32'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
    tick(); set_issue(5'd5, 4'd3);
    tick(); idle(); set_rs(5'd5, 5'd0);
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL reset_pre_stall: got %b want 1", stall); end
    tick();
    vectors++; if (stall_cycles !== 32'd1) begin miscompares++; $display("FAIL reset_pre_cnt: got %0d want 1", stall_cycles); end
    set_res(0, 5'd5, 4'd3, 64'h55);
    tick(); idle(); set_rs(5'd5, 5'd0);
    @(negedge clk);
    vectors++; if (fwd_data[63:0] !== 64'h55) begin miscompares++; $display("FAIL reset_capt: got %h want 55", fwd_data[63:0]); end
    #1 rst_n = 0;
    #1;
    vectors++; if (fwd_sel !== 2'b00) begin miscompares++; $display("FAIL reset_async_sel: got %b want 00", fwd_sel); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_async_stall: got %b want 0", stall); end
    vectors++; if (stall_cycles !== 32'd0) begin miscompares++; $display("FAIL reset_async_cnt: got %0d want 0", stall_cycles); end
    tick(); rst_n = 1;
  endtask

  task automatic test_bypass();
    rst_pulse();
    set_issue(5'd5, 4'd2);
    tick(); idle(); set_rs(5'd5, 5'd0);
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL byp_stall: got %b want 1", stall); end
    vectors++; if (fwd_sel !== 2'b01) begin miscompares++; $display("FAIL byp_sel_wait: got %b want 01", fwd_sel); end
    set_res(1, 5'd5, 4'd2, 64'hAB);
    #1;
    vectors++; if (fwd_data[63:0] !== 64'hAB) begin miscompares++; $display("FAIL byp_zero_lat: got %h want ab", fwd_data[63:0]); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL byp_stall_clr: got %b want 0", stall); end
    tick(); idle(); set_rs(5'd5, 5'd0);
    @(negedge clk);
    vectors++; if (fwd_data[63:0] !== 64'hAB || fwd_sel !== 2'b01) begin miscompares++; $display("FAIL byp_held: got %b/%h want 01/ab", fwd_sel, fwd_data[63:0]); end
    vectors++; if (stall_cycles !== 32'd0) begin miscompares++; $display("FAIL byp_cnt: got %0d want 0", stall_cycles); end
    tick();
  endtask

  task automatic test_stale_tag();
    rst_pulse();
    set_issue(5'd7, 4'd1);
    tick(); idle(); set_issue(5'd7, 4'd4);
    tick(); idle(); set_rs(5'd0, 5'd7); set_res(0, 5'd7, 4'd1, 64'h11);
    @(negedge clk);
    vectors++; if (stall !== 1'b1 || fwd_sel !== 2'b10) begin miscompares++; $display("FAIL stale_ignore: got %b/%b want 1/10", stall, fwd_sel); end
    vectors++; if (fwd_data[127:64] !== 64'h0) begin miscompares++; $display("FAIL stale_data: got %h want 0", fwd_data[127:64]); end
    tick(); idle(); set_rs(5'd0, 5'd7);
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL stale_persist: got %b want 1", stall); end
    set_res(2, 5'd7, 4'd4, 64'h44);
    #1;
    vectors++; if (fwd_data[127:64] !== 64'h44 || stall !== 1'b0) begin miscompares++; $display("FAIL stale_new: got %h/%b want 44/0", fwd_data[127:64], stall); end
    tick(); idle(); set_rs(5'd0, 5'd7);
    @(negedge clk);
    vectors++; if (fwd_data[127:64] !== 64'h44) begin miscompares++; $display("FAIL stale_capt: got %h want 44", fwd_data[127:64]); end
    vectors++; if (stall_cycles !== 32'd1) begin miscompares++; $display("FAIL stale_cnt: got %0d want 1", stall_cycles); end
    tick();
  endtask

  task automatic test_commit();
    rst_pulse();
    set_issue(5'd5, 4'd2);
    tick(); idle(); set_res(0, 5'd5, 4'd2, 64'h77);
    tick(); idle(); set_cmt(5'd5, 4'd2); set_rs(5'd5, 5'd0);
    @(negedge clk);
    vectors++; if (fwd_sel !== 2'b01 || fwd_data[63:0] !== 64'h77) begin miscompares++; $display("FAIL cmt_same_cyc: got %b/%h want 01/77", fwd_sel, fwd_data[63:0]); end
    tick(); idle(); set_rs(5'd5, 5'd0);
    @(negedge clk);
    vectors++; if (fwd_sel !== 2'b00 || fwd_data !== '0) begin miscompares++; $display("FAIL cmt_cleared: got %b/%h want 00/0", fwd_sel, fwd_data); end
    set_issue(5'd5, 4'd2);
    tick(); idle(); set_issue(5'd5, 4'd6); set_cmt(5'd5, 4'd2);
    tick(); idle(); set_rs(5'd5, 5'd0); set_res(0, 5'd5, 4'd2, 64'h22);
    @(negedge clk);
    vectors++; if (stall !== 1'b1 || fwd_sel !== 2'b01) begin miscompares++; $display("FAIL cmt_issue_win: got %b/%b want 1/01", stall, fwd_sel); end
    set_res(0, 5'd5, 4'd6, 64'h66);
    #1;
    vectors++; if (fwd_data[63:0] !== 64'h66) begin miscompares++; $display("FAIL cmt_newtag: got %h want 66", fwd_data[63:0]); end
    tick(); idle(); set_cmt(5'd5, 4'd2);
    tick(); idle(); set_rs(5'd5, 5'd0);
    @(negedge clk);
    vectors++; if (fwd_sel !== 2'b01 || fwd_data[63:0] !== 64'h66) begin miscompares++; $display("FAIL cmt_mismatch: got %b/%h want 01/66", fwd_sel, fwd_data[63:0]); end
    tick();
  endtask

  task automatic test_port_priority();
    rst_pulse();
    set_issue(5'd9, 4'd3);
    tick(); idle(); set_rs(5'd9, 5'd0);
    set_res(0, 5'd9, 4'd3, 64'h1); set_res(2, 5'd9, 4'd3, 64'h2);
    @(negedge clk);
    vectors++; if (fwd_data[63:0] !== 64'h1 || fwd_sel !== 2'b01) begin miscompares++; $display("FAIL prio_bypass: got %b/%h want 01/1", fwd_sel, fwd_data[63:0]); end
    tick(); idle(); set_rs(5'd9, 5'd0);
    @(negedge clk);
    vectors++; if (fwd_data[63:0] !== 64'h1) begin miscompares++; $display("FAIL prio_capture: got %h want 1", fwd_data[63:0]); end
    set_issue(5'd0, 4'd5);
    tick(); idle(); issue_valid = 1; issue_rd = 5'd10; issue_tag = 4'd1;
    tick(); idle(); set_rs(5'd10, 5'd0); set_res(1, 5'd0, 4'd5, 64'h9);
    @(negedge clk);
    vectors++; if (fwd_sel !== 2'b00 || stall !== 1'b0) begin miscompares++; $display("FAIL prio_rd0_nowen: got %b/%b want 00/0", fwd_sel, stall); end
    tick();
  endtask

  task automatic test_flush();
    rst_pulse();
    set_issue(5'd3, 4'd1);
    tick(); idle(); set_issue(5'd4, 4'd2);
    tick(); idle(); set_issue(5'd6, 4'd3);
    tick(); idle(); set_rs(5'd3, 5'd4);
    repeat (5) tick();
    @(negedge clk);
    vectors++; if (stall_cycles !== 32'd5) begin miscompares++; $display("FAIL flush_cnt5: got %0d want 5", stall_cycles); end
    flush = 1; set_issue(5'd8, 4'd7);
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall_mask: got %b want 0", stall); end
    tick(); idle(); set_rs(5'd3, 5'd6);
    @(negedge clk);
    vectors++; if (fwd_sel !== 2'b00) begin miscompares++; $display("FAIL flush_clear: got %b want 00", fwd_sel); end
    set_rs(5'd8, 5'd4);
    #1;
    vectors++; if (fwd_sel !== 2'b00 || stall !== 1'b0) begin miscompares++; $display("FAIL flush_drop_issue: got %b/%b want 00/0", fwd_sel, stall); end
    vectors++; if (stall_cycles !== 32'd5) begin miscompares++; $display("FAIL flush_cnt_keep: got %0d want 5", stall_cycles); end
    tick();
  endtask

  task automatic test_random();
    logic [NRD-1:0] es;
    logic [NRD*XLEN-1:0] ed;
    logic est;
    bit found;
    bit op[NREG];
    int ot[NREG];
    int r, t;
    rst_pulse();
    for (int k = 0; k < NREG; k++) begin
      mp[k] = 0; mr[k] = 0; mt[k] = 0; mv[k] = '0;
    end
    mcnt = 0;
    for (int n = 0; n < 600; n++) begin
      idle();
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_rd_wen = ($urandom_range(0, 3) != 0);
      issue_rd = LW'($urandom_range(0, 7));
      issue_tag = TAG_W'($urandom);
      for (int i = 0; i < NRES; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 7);
          t = ($urandom_range(0, 2) != 0) ? mt[r] : $urandom_range(0, 15);
          set_res(i, LW'(r), TAG_W'(t), {$urandom, $urandom});
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 7);
        t = ($urandom_range(0, 2) != 0) ? mt[r] : $urandom_range(0, 15);
        set_cmt(LW'(r), TAG_W'(t));
      end
      flush = ($urandom_range(0, 31) == 0);
      set_rs(LW'($urandom_range(0, 7)), LW'($urandom_range(0, 7)));
      @(negedge clk);
      es = '0; ed = '0; est = 0;
      for (int j = 0; j < NRD; j++) begin
        r = int'(rs_addr[j*LW +: LW]);
        if (r != 0 && mp[r]) begin
          es[j] = 1'b1;
          if (mr[r]) ed[j*XLEN +: XLEN] = mv[r];
          else begin
            found = 0;
            for (int i = 0; i < NRES; i++)
              if (!found && res_valid[i] && int'(res_rd[i*LW +: LW]) == r &&
                  int'(res_tag[i*TAG_W +: TAG_W]) == mt[r]) begin
                found = 1;
                ed[j*XLEN +: XLEN] = res_data[i*XLEN +: XLEN];
              end
            if (!found) est = 1;
          end
        end
      end
      if (flush) est = 0;
      vectors++; if (fwd_sel !== es) begin miscompares++; $display("FAIL rand_sel cyc %0d: got %b want %b", n, fwd_sel, es); end
      vectors++; if (fwd_data !== ed) begin miscompares++; $display("FAIL rand_data cyc %0d: got %h want %h", n, fwd_data, ed); end
      vectors++; if (stall !== est) begin miscompares++; $display("FAIL rand_stall cyc %0d: got %b want %b", n, stall, est); end
      vectors++; if (stall_cycles !== 32'(mcnt)) begin miscompares++; $display("FAIL rand_cnt cyc %0d: got %0d want %0d", n, stall_cycles, mcnt); end
      // Apply events lowest priority first so later ones overwrite.
      op = mp; ot = mt;
      for (int i = NRES - 1; i >= 0; i--) begin
        r = int'(res_rd[i*LW +: LW]);
        if (res_valid[i] && op[r] && int'(res_tag[i*TAG_W +: TAG_W]) == ot[r]) begin
          mr[r] = 1; mv[r] = res_data[i*XLEN +: XLEN];
        end
      end
      r = int'(cmt_rd);
      if (cmt_valid && op[r] && int'(cmt_tag) == ot[r]) begin
        mp[r] = 0; mr[r] = 0;
      end
      r = int'(issue_rd);
      if (issue_valid && issue_rd_wen && r != 0) begin
        mp[r] = 1; mr[r] = 0; mt[r] = int'(issue_tag);
      end
      if (flush)
        for (int k = 0; k < NREG; k++) begin mp[k] = 0; mr[k] = 0; end
      if (est) mcnt++;
      tick();
    end
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_bypass();
    test_stale_tag();
    test_commit();
    test_port_priority();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bypass_scoreboard.md
Name: bypass_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding unit. It replaces fixed per-stage rd comparisons with a per-register scoreboard that tracks in-flight producers by tag.
- Result values are captured as they are produced, so they can be forwarded after the producer has left its stage.
- Sits between decode/issue and the register file. Serves NRD operand lookups per cycle from NRES result broadcast ports and drives the decode stall.

Parameters:
- XLEN, 64, data width
- NREG, 32, architectural registers; register 0 is hardwired zero
- NRD, 2, operand lookup ports
- NRES, 3, result broadcast ports (e.g. EXA, MEMR, late ALU)
- TAG_W, 4, in-flight instruction tag width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction issues this cycle
- issue_rd_wen  in  1  issuing instruction writes rd
- issue_rd  in  log2(NREG)  destination register
- issue_tag  in  TAG_W  tag of issuing instruction
- res_valid  in  NRES  per-port result valid
- res_rd  in  NRES*log2(NREG)  packed destination per port
- res_tag  in  NRES*TAG_W  packed tag per port
- res_data  in  NRES*XLEN  packed result data per port
- cmt_valid  in  1  instruction written to register file this cycle
- cmt_rd  in  log2(NREG)  committed destination
- cmt_tag  in  TAG_W  committed tag
- flush  in  1  squash all in-flight producers
- rs_addr  in  NRD*log2(NREG)  packed lookup addresses
- fwd_sel  out  NRD  1 = use fwd_data, 0 = use register file
- fwd_data  out  NRD*XLEN  forwarded operand
- stall  out  1  some lookup has a pending producer with no data
- stall_cycles  out  32  saturating count of cycles with stall=1

Behaviour:
- Per-register state: pending, ready, tag[TAG_W], val[XLEN]. Register 0 is never pending.
- Reset (rst_n low, asynchronous): all pending, ready and val cleared; stall_cycles=0. fwd_sel, fwd_data and stall are 0 because no register is pending.
- Issue (clock edge):
  - Applies when issue_valid & issue_rd_wen & issue_rd≠0.
  - Sets pending=1, ready=0, tag=issue_tag.
  - Overwrites any older producer of the same rd; the older producer's later result or commit is then stale.
- Result capture:
  - Applies when res_valid[i], res_rd[i] is pending, and res_tag[i]==tag[res_rd[i]].
  - Sets ready=1 and val=res_data[i].
  - Tag mismatch is ignored.
  - If several ports match the same rd, the lowest index wins.
- Commit:
  - Applies when cmt_valid, cmt_rd is pending, and cmt_tag matches.
  - Clears pending and ready. The register file now holds the value.
  - Tag mismatch is ignored.
- Same-cycle priority on one rd: flush > issue > commit > result capture.
  - Issue and matching commit on the same rd: pending stays 1 with the new tag.
  - Result and commit with the same tag: entry ends cleared.
- Flush: clears every pending and ready bit. A same-cycle issue is dropped. stall_cycles is unaffected.
- Lookup (combinational, per port j, from registered state plus this cycle's result ports; a same-cycle issue is never visible):
  - rs=0 or not pending: fwd_sel=0, fwd_data=0.
  - pending & ready: fwd_sel=1, fwd_data=val.
  - pending & !ready & some res port matches (rd and tag) this cycle: fwd_sel=1, fwd_data=that res_data (lowest index wins). This is zero-latency bypass.
  - Otherwise: fwd_sel=1, fwd_data=0, and the port requests a stall.
- stall = OR of all port stall requests; forced to 0 while flush=1.
- stall_cycles increments on each clock with stall=1 and saturates at 0xFFFF_FFFF.
- Issue while stall=1 is the issuer's error. The block still records it.
- No internal state machine beyond the scoreboard. Latency:
  - A captured result is forwardable from the next cycle.
  - A same-cycle result is forwardable combinationally.
  - A commit makes the register-file value visible from the next cycle.

Test Plan:
- Reset mid-operation: after issue rd=5 tag=3 and a result capture, drop rst_n → fwd_sel=0, stall=0, stall_cycles=0 immediately.
- Issue rd=5 tag=2; next cycle lookup rs0=5 with no result → stall=1. Then res port1 rd=5 tag=2 data=0xAB → same cycle fwd_sel[0]=1, fwd_data=0xAB, stall=0. Following cycle still 0xAB from val.
- Issue rd=7 tag=1, then issue rd=7 tag=4. Result rd=7 tag=1 data=0x11 → ignored, stall persists. Result tag=4 data=0x44 → forwards 0x44.
- Commit rd=5 tag=2 → next cycle lookup rs=5 gives fwd_sel=0. Same-cycle issue rd=5 tag=6 plus commit tag=2 → pending remains with tag 6.
- Ports 0 and 2 both present rd=9 tag=3 with data 0x1 and 0x2 → fwd_data=0x1. Lookup rs=0 always gives fwd_sel=0.
- Flush with three pending registers plus a same-cycle issue → all lookups fwd_sel=0 the next cycle, issue dropped. Hold stall for 5 cycles beforehand → stall_cycles=5.
